// File: rtl/rob_queue.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order retire.
// Branch mispredicts detected at retirement flush the whole buffer.
// Optional feature macro: ROB_FWD_EN adds two combinational operand lookup ports.
module rob_queue #(
    parameter int unsigned DEPTH_LOG = 3,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_WB    = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    input  logic [1:0]                    issue_type,
    input  logic                          issue_pred_taken,
    output logic [DEPTH_LOG-1:0]          issue_idx,
    output logic                          full,
    output logic                          empty,
    input  logic [NUM_WB-1:0]             wb_valid,
    input  logic [NUM_WB*DEPTH_LOG-1:0]   wb_idx,
    input  logic [NUM_WB*XLEN-1:0]        wb_value,
    input  logic [NUM_WB-1:0]             wb_taken,
`ifdef ROB_FWD_EN
    input  logic [DEPTH_LOG-1:0]          qry_idx_a,
    input  logic [DEPTH_LOG-1:0]          qry_idx_b,
    output logic                          qry_hit_a,
    output logic                          qry_hit_b,
    output logic [XLEN-1:0]               qry_val_a,
    output logic [XLEN-1:0]               qry_val_b,
`endif
    output logic                          commit_valid,
    output logic [4:0]                    commit_rd,
    output logic [XLEN-1:0]               commit_value,
    output logic [DEPTH_LOG-1:0]          commit_idx,
    output logic                          commit_is_store,
    output logic                          flush_out,
    output logic [XLEN-1:0]               flush_pc
);

    localparam int unsigned DEPTH       = 1 << DEPTH_LOG;
    localparam logic [1:0]  TYPE_STORE  = 2'b01;
    localparam logic [1:0]  TYPE_BRANCH = 2'b10;

    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     ready_q;
    logic [DEPTH-1:0]     pred_q;
    logic [DEPTH-1:0]     taken_q;
    logic [4:0]           rd_q    [DEPTH];
    logic [1:0]           type_q  [DEPTH];
    logic [XLEN-1:0]      value_q [DEPTH];
    logic [DEPTH_LOG-1:0] head_q;
    logic [DEPTH_LOG-1:0] tail_q;
    logic [DEPTH_LOG:0]   count_q;

    // Writeback results resolved per entry; later channels overwrite earlier ones.
    logic [DEPTH-1:0]     wb_hit;
    logic [DEPTH-1:0]     wb_tkn;
    logic [XLEN-1:0]      wb_val [DEPTH];

    logic issue_accept;
    logic do_commit;
    logic mispredict;

    assign full         = (count_q == (DEPTH_LOG+1)'(DEPTH));
    assign empty        = (count_q == '0);
    assign issue_idx    = tail_q;
    assign issue_accept = rdy_in && issue_valid && !full;
    assign do_commit    = rdy_in && busy_q[head_q] && ready_q[head_q];
    assign mispredict   = do_commit && (type_q[head_q] == TYPE_BRANCH) &&
                          (taken_q[head_q] != pred_q[head_q]);

    // Fold all writeback channels into per-entry hit/value/taken, highest channel wins.
    always_comb begin
        wb_hit = '0;
        wb_tkn = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wb_val[i] = '0;
        end
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k]) begin
                wb_hit[wb_idx[k*DEPTH_LOG +: DEPTH_LOG]] = 1'b1;
                wb_tkn[wb_idx[k*DEPTH_LOG +: DEPTH_LOG]] = wb_taken[k];
                wb_val[wb_idx[k*DEPTH_LOG +: DEPTH_LOG]] = wb_value[k*XLEN +: XLEN];
            end
        end
    end

`ifdef ROB_FWD_EN
    // Operand lookup: registered ready entries, overridden by same-cycle writebacks.
    always_comb begin
        qry_hit_a = busy_q[qry_idx_a] && (ready_q[qry_idx_a] || wb_hit[qry_idx_a]);
        qry_hit_b = busy_q[qry_idx_b] && (ready_q[qry_idx_b] || wb_hit[qry_idx_b]);
        qry_val_a = wb_hit[qry_idx_a] ? wb_val[qry_idx_a] : value_q[qry_idx_a];
        qry_val_b = wb_hit[qry_idx_b] ? wb_val[qry_idx_b] : value_q[qry_idx_b];
    end
`endif

    // Entry state, pointers and registered commit/flush outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q          <= '0;
            ready_q         <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_valid    <= 1'b0;
            commit_rd       <= '0;
            commit_value    <= '0;
            commit_idx      <= '0;
            commit_is_store <= 1'b0;
            flush_out       <= 1'b0;
            flush_pc        <= '0;
        end else if (!rdy_in) begin
            commit_valid <= 1'b0;
            flush_out    <= 1'b0;
        end else begin
            commit_valid <= 1'b0;
            flush_out    <= 1'b0;
            if (do_commit) begin
                commit_valid    <= 1'b1;
                commit_rd       <= rd_q[head_q];
                commit_value    <= value_q[head_q];
                commit_idx      <= head_q;
                commit_is_store <= (type_q[head_q] == TYPE_STORE);
            end
            if (mispredict) begin
                // Everything younger than the branch is wrong-path: drop it all.
                flush_out <= 1'b1;
                flush_pc  <= value_q[head_q];
                busy_q    <= '0;
                head_q    <= '0;
                tail_q    <= '0;
                count_q   <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wb_hit[i] && busy_q[i]) begin
                        ready_q[i] <= 1'b1;
                        value_q[i] <= wb_val[i];
                        taken_q[i] <= wb_tkn[i];
                    end
                end
                if (do_commit) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + 1'b1;
                end
                // Tail is never busy when issue is accepted, so no clash with writeback.
                if (issue_accept) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    rd_q[tail_q]    <= issue_rd;
                    type_q[tail_q]  <= issue_type;
                    pred_q[tail_q]  <= issue_pred_taken;
                    tail_q          <= tail_q + 1'b1;
                end
                count_q <= count_q + (DEPTH_LOG+1)'(issue_accept) - (DEPTH_LOG+1)'(do_commit);
            end
        end
    end

endmodule

// File: tb/tb_rob_queue.sv
// Directed self-checking bench for rob_queue (default build, DEPTH_LOG=3, NUM_WB=2).
module tb_rob_queue;

    localparam int unsigned DL = 3;
    localparam int unsigned XL = 32;
    localparam int unsigned NW = 2;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [1:0]    issue_type;
    logic          issue_pred_taken;
    logic [DL-1:0] issue_idx;
    logic          full;
    logic          empty;
    logic [NW-1:0]    wb_valid;
    logic [NW*DL-1:0] wb_idx;
    logic [NW*XL-1:0] wb_value;
    logic [NW-1:0]    wb_taken;
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic [XL-1:0] commit_value;
    logic [DL-1:0] commit_idx;
    logic          commit_is_store;
    logic          flush_out;
    logic [XL-1:0] flush_pc;

    int errors = 0;
    int checks = 0;

    rob_queue #(.DEPTH_LOG(DL), .XLEN(XL), .NUM_WB(NW)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_type       (issue_type),
        .issue_pred_taken (issue_pred_taken),
        .issue_idx        (issue_idx),
        .full             (full),
        .empty            (empty),
        .wb_valid         (wb_valid),
        .wb_idx           (wb_idx),
        .wb_value         (wb_value),
        .wb_taken         (wb_taken),
        .commit_valid     (commit_valid),
        .commit_rd        (commit_rd),
        .commit_value     (commit_value),
        .commit_idx       (commit_idx),
        .commit_is_store  (commit_is_store),
        .flush_out        (flush_out),
        .flush_pc         (flush_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic iss(input logic [4:0] rd, input logic [1:0] typ, input logic pt);
        issue_valid      = 1'b1;
        issue_rd         = rd;
        issue_type       = typ;
        issue_pred_taken = pt;
    endtask

    task automatic wb(input int ch, input logic [DL-1:0] idx, input logic [XL-1:0] val,
                      input logic tk);
        wb_valid[ch]         = 1'b1;
        wb_idx[ch*DL +: DL]  = idx;
        wb_value[ch*XL +: XL] = val;
        wb_taken[ch]         = tk;
    endtask

    task automatic chk_commit(input string tag, input logic [4:0] rd, input logic [XL-1:0] val,
                              input logic [DL-1:0] idx);
        chk({tag, "_valid"}, commit_valid, 1);
        chk({tag, "_rd"},    commit_rd,    rd);
        chk({tag, "_value"}, commit_value, val);
        chk({tag, "_idx"},   commit_idx,   idx);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        issue_valid = 1'b0; issue_rd = '0; issue_type = '0; issue_pred_taken = 1'b0;
        wb_valid = '0; wb_idx = '0; wb_value = '0; wb_taken = '0;
        step(); step();
        rst_in = 1'b0;

        // Reset state
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_flush_out",    flush_out, 0);
        chk("rst_commit_rd",    commit_rd, 0);
        chk("rst_commit_value", commit_value, 0);
        chk("rst_commit_idx",   commit_idx, 0);
        chk("rst_commit_store", commit_is_store, 0);
        chk("rst_flush_pc",     flush_pc, 0);
        chk("rst_full",         full, 0);
        chk("rst_empty",        empty, 1);
        chk("rst_issue_idx",    issue_idx, 0);

        // Fill all 8 entries
        for (int i = 0; i < 8; i++) begin
            chk("fill_issue_idx", issue_idx, i);
            chk("fill_not_full", full, 0);
            iss(5'(i + 1), 2'b11, 1'b0);
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_wrap_idx", issue_idx, 0);
        chk("fill_not_empty", empty, 0);
        // 9th issue ignored
        step();
        chk("over_full", full, 1);
        chk("over_idx", issue_idx, 0);
        chk("over_no_commit", commit_valid, 0);

        // Full buffer with head ready: commit happens, issue rejected
        wb(0, 3'd0, 32'h55, 1'b0);
        step();
        chk("fullwb_no_commit", commit_valid, 0);
        chk("fullwb_full", full, 1);
        wb_valid = '0;
        step();
        chk_commit("full_commit", 5'd1, 32'h55, 3'd0);
        chk("full_commit_count7", full, 0);
        chk("full_commit_rejected", issue_idx, 0);
        chk("full_commit_nonempty", empty, 0);
        issue_valid = 1'b0;

        // Reset mid-operation discards everything
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("midrst_empty", empty, 1);
        chk("midrst_idx", issue_idx, 0);
        chk("midrst_commit", commit_valid, 0);
        chk("midrst_flush", flush_out, 0);

        // Out-of-order writeback, in-order commit
        iss(5'd5, 2'b00, 1'b0); step();
        iss(5'd6, 2'b00, 1'b0); step();
        iss(5'd7, 2'b00, 1'b0); step();
        issue_valid = 1'b0;
        wb(0, 3'd2, 32'h30, 1'b0); step();
        chk("ooo_wait1", commit_valid, 0);
        wb(0, 3'd0, 32'h10, 1'b0); step();
        chk("ooo_wait2", commit_valid, 0);
        wb(0, 3'd1, 32'h20, 1'b0); step();
        wb_valid = '0;
        chk_commit("ooo_c0", 5'd5, 32'h10, 3'd0);
        step();
        chk_commit("ooo_c1", 5'd6, 32'h20, 3'd1);
        step();
        chk_commit("ooo_c2", 5'd7, 32'h30, 3'd2);
        step();
        chk("ooo_done_valid", commit_valid, 0);
        chk("ooo_done_empty", empty, 1);
        chk("ooo_tail", issue_idx, 3);

        // Two channels on one entry: channel 1 wins; store flag propagates
        iss(5'd0, 2'b01, 1'b0); step();
        issue_valid = 1'b0;
        wb(0, 3'd3, 32'hAA, 1'b0);
        wb(1, 3'd3, 32'hBB, 1'b0);
        step();
        wb_valid = '0;
        step();
        chk_commit("prio", 5'd0, 32'hBB, 3'd3);
        chk("prio_store", commit_is_store, 1);

        // rdy_in low freezes the block mid-stream
        iss(5'd10, 2'b00, 1'b0); step();
        iss(5'd11, 2'b00, 1'b0); step();
        iss(5'd12, 2'b00, 1'b0); step();
        issue_valid = 1'b0;
        chk("prio_store_clear_after", commit_valid, 0);
        wb(0, 3'd4, 32'h40, 1'b0);
        wb(1, 3'd5, 32'h50, 1'b0);
        step();
        wb_valid = '0;
        wb(0, 3'd6, 32'h60, 1'b0);
        step();
        chk_commit("rdy_c0", 5'd10, 32'h40, 3'd4);
        chk("rdy_c0_store", commit_is_store, 0);
        wb_valid = '0;
        rdy_in = 1'b0;
        iss(5'd1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_no_commit", commit_valid, 0);
            chk("frz_tail", issue_idx, 7);
            chk("frz_hold_rd", commit_rd, 10);
        end
        rdy_in = 1'b1;
        issue_valid = 1'b0;
        step();
        chk_commit("rdy_c1", 5'd11, 32'h50, 3'd5);
        step();
        chk_commit("rdy_c2", 5'd12, 32'h60, 3'd6);
        step();
        chk("rdy_done", commit_valid, 0);
        chk("rdy_empty", empty, 1);

        // Mispredicted branch with two younger entries in flight
        iss(5'd0, 2'b10, 1'b0); step();
        iss(5'd20, 2'b00, 1'b0); step();
        iss(5'd21, 2'b00, 1'b0); step();
        issue_valid = 1'b0;
        chk("br_wrap_idx", issue_idx, 2);
        wb(0, 3'd7, 32'h1000, 1'b1);
        wb(1, 3'd0, 32'h11, 1'b0);
        step();
        wb_valid = '0;
        wb(0, 3'd1, 32'h22, 1'b0);
        iss(5'd9, 2'b00, 1'b0);
        step();
        chk("br_commit_valid", commit_valid, 1);
        chk("br_commit_idx", commit_idx, 7);
        chk("br_flush", flush_out, 1);
        chk("br_flush_pc", flush_pc, 32'h1000);
        chk("br_empty", empty, 1);
        chk("br_idx", issue_idx, 0);
        wb_valid = '0;
        issue_valid = 1'b0;
        step();
        chk("br_after_valid", commit_valid, 0);
        chk("br_after_flush", flush_out, 0);
        chk("br_after_empty", empty, 1);
        chk("br_after_idx", issue_idx, 0);
        step();
        chk("br_young_never", commit_valid, 0);

        // Correctly predicted branch retires without flush
        iss(5'd0, 2'b10, 1'b1); step();
        issue_valid = 1'b0;
        wb(0, 3'd0, 32'h2000, 1'b1); step();
        wb_valid = '0;
        step();
        chk("brok_commit", commit_valid, 1);
        chk("brok_no_flush", flush_out, 0);
        chk("brok_idx", commit_idx, 0);
        chk("brok_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_queue.md
# rob_queue

Parametrised reorder buffer between the issue stage and the register file / load-store buffer. Allocates one entry per issued instruction in program order and accepts out-of-order results from NUM_WB writeback channels (RS, LSB, ...). Retires at most one entry per cycle in order. Detects branch mispredictions at retirement and flushes itself and the pipeline.

## Interface
- DEPTH_LOG, 3: log2 of entry count; DEPTH = 2^DEPTH_LOG.
- XLEN, 32: data width.
- NUM_WB, 2: number of writeback channels; channel 0 = RS, channel 1 = LSB.

- clk_in  in  1  clock; all state updates on posedge.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global enable; low freezes the block.
- issue_valid  in  1  allocate an entry this cycle.
- issue_rd  in  5  destination register; 0 = no register write.
- issue_type  in  2  00 reg-writing op, 01 store, 10 branch, 11 other.
- issue_pred_taken  in  1  predicted direction, branches only.
- issue_idx  out  DEPTH_LOG  index the next issue receives (= tail).
- full  out  1  count == DEPTH; combinational from count.
- empty  out  1  count == 0.
- wb_valid  in  NUM_WB  per-channel result valid.
- wb_idx  in  NUM_WB*DEPTH_LOG  packed target entry indices; channel k at [k*DEPTH_LOG +: DEPTH_LOG].
- wb_value  in  NUM_WB*XLEN  packed results; for branches, the correct next PC.
- wb_taken  in  NUM_WB  actual branch direction.
- commit_valid  out  1  one-cycle retire pulse.
- commit_rd  out  5  retired destination register.
- commit_value  out  XLEN  retired value.
- commit_idx  out  DEPTH_LOG  retired entry index.
- commit_is_store  out  1  retired entry is a store; LSB performs it.
- flush_out  out  1  one-cycle mispredict pulse, coincident with commit_valid.
- flush_pc  out  XLEN  redirect PC, valid with flush_out.

## Operation
- Per-entry state: busy, ready, rd, type, pred_taken, taken, value. Pointers head and tail are DEPTH_LOG bits and wrap modulo DEPTH. count is DEPTH_LOG+1 bits.
- Issue: accepted iff issue_valid && !full. The entry at tail gets busy=1 and ready=0. tail increments.
- Writeback: for each k with wb_valid[k] whose target entry is busy, set ready=1 and write value and taken. A writeback to a non-busy entry is ignored. If several channels hit the same index in one cycle, the highest k wins.
- Commit: if the head entry is busy and ready, register the commit_* outputs, pulse commit_valid, clear busy, and increment head.
- Mispredict: a committing branch with taken != pred_taken asserts flush_out and sets flush_pc = value. On that same edge all busy bits clear, head = tail = count = 0, and any concurrent issue or writeback is discarded.
- count next = count + issue_accept - commit. Issue and commit may occur in the same cycle. full is evaluated before that cycle's commit: there is no same-cycle bypass, so a full buffer rejects issue even while retiring.
- rdy_in low: no state changes and issue is not accepted. commit_valid and flush_out clear at that edge; all other registers hold.

## Timing
- Reset: head = tail = count = 0, all busy = ready = 0. Outputs reset to: commit_valid = 0, flush_out = 0, commit_rd = 0, commit_value = 0, commit_idx = 0, commit_is_store = 0, flush_pc = 0. full = 0, empty = 1, issue_idx = 0.
- Reset mid-operation discards every entry. There is no flush_out on reset.
- Issue at edge N: the entry can accept writeback from cycle N onward.
- Writeback at edge N to the head entry: commit_valid is high during cycle N+1 (after edge N+1). Minimum issue-to-commit latency is 2 edges (issue edge, writeback edge).
- Sustained throughput is 1 commit per cycle with writebacks ahead.

## Configuration
- ROB_FWD_EN defined: adds two operand-lookup ports per side, for a and b:
  - qry_idx_a/qry_idx_b  in  DEPTH_LOG
  - qry_hit_a/qry_hit_b  out  1
  - qry_val_a/qry_val_b  out  XLEN
  - Lookup is combinational. hit = busy && ready at the queried entry, val = that entry's value. Same-cycle writebacks are also forwarded, with highest channel priority.
- ROB_FWD_EN undefined: these ports are absent. Issue must wait for commit or CDB broadcast.

## Test plan
- Reset, then issue 8 entries with DEPTH_LOG=3: full=1 after 8th edge, issue_idx wraps to 0, 9th issue_valid ignored (count stays 8).
- Issue rd=5,6,7; writeback idx2=0x30, idx0=0x10, idx1=0x20 on successive cycles: commits in order rd5/0x10, rd6/0x20, rd7/0x30, one per cycle.
- Channels 0 and 1 both write idx 3 in one cycle (0xAA, 0xBB): committed value 0xBB.
- Branch pred_taken=0, wb_taken=1, value=0x1000, two younger entries busy: flush_out=1 and flush_pc=0x1000 with commit; next cycle empty=1 and issue_idx=0; younger entries never commit.
- Full buffer, head ready, issue_valid=1: commit occurs, issue rejected, count=7 after edge. rdy_in=0 for 3 cycles mid-stream: no commits, pointers unchanged; resumes identically.
